// File: rtl/imem_port_arbiter_if.sv
// Bundle between fetch/loader requesters, the arbiter and SRAM RW port 0.
// master = requester + macro side, slave = arbiter.
interface imem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SRAM_AW    = 8
);
  logic                  fetch_req_i;
  logic [ADDR_WIDTH-1:0] fetch_addr_i;
  logic                  fetch_gnt_o;
  logic                  fetch_rvalid_o;
  logic [DATA_WIDTH-1:0] fetch_rdata_o;
  logic                  fetch_err_o;
  logic                  load_req_i;
  logic [ADDR_WIDTH-1:0] load_addr_i;
  logic [DATA_WIDTH-1:0] load_wdata_i;
  logic [3:0]            load_be_i;
  logic                  load_gnt_o;
  logic                  load_err_o;
  logic                  sram_csb0_o;
  logic                  sram_web0_o;
  logic [3:0]            sram_wmask0_o;
  logic [SRAM_AW-1:0]    sram_addr0_o;
  logic [DATA_WIDTH-1:0] sram_din0_o;
  logic [DATA_WIDTH-1:0] sram_dout0_i;

  modport master (
    output fetch_req_i, fetch_addr_i,
    output load_req_i, load_addr_i,
    output load_wdata_i, load_be_i,
    output sram_dout0_i,
    input  fetch_gnt_o, fetch_rvalid_o,
    input  fetch_rdata_o, fetch_err_o,
    input  load_gnt_o, load_err_o,
    input  sram_csb0_o, sram_web0_o,
    input  sram_wmask0_o, sram_addr0_o,
    input  sram_din0_o
  );

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    input  load_req_i, load_addr_i,
    input  load_wdata_i, load_be_i,
    input  sram_dout0_i,
    output fetch_gnt_o, fetch_rvalid_o,
    output fetch_rdata_o, fetch_err_o,
    output load_gnt_o, load_err_o,
    output sram_csb0_o, sram_web0_o,
    output sram_wmask0_o, sram_addr0_o,
    output sram_din0_o
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares imem SRAM RW port 0 between fetch reads and loader writes.
// Optional stall counter: define IMEM_STALL_CNT_EN.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SRAM_AW    = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_port_arbiter_if.slave bus,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD
  } state_t;

  state_t state_q, state_d;

  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY-1:0] err_q;
  logic [DATA_WIDTH-1:0] dat_q [1:RD_LATENCY-1];

  logic                  fetch_bad;
  logic                  load_bad;
  logic                  busy;
  logic                  fetch_gnt;
  logic                  load_gnt;
  logic                  load_err;
  logic                  csb;
  logic                  web;
  logic [3:0]            wmask;
  logic [SRAM_AW-1:0]    addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  unused_load_lsb;

  assign fetch_bad =
    (bus.fetch_addr_i[1:0] != 2'b00) |
    (bus.fetch_addr_i[ADDR_WIDTH-1:SRAM_AW+2] != '0);
  assign load_bad =
    bus.load_addr_i[ADDR_WIDTH-1:SRAM_AW+2] != '0;
  assign busy = |vld_q;
  assign unused_load_lsb = ^bus.load_addr_i[1:0];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state, grants and SRAM port drive
  always_comb begin
    state_d   = state_q;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    load_err  = 1'b0;
    csb       = 1'b1;
    web       = 1'b1;
    wmask     = 4'h0;
    addr      = '0;
    din       = '0;
    unique case (state_q)
      RUN: begin
        fetch_gnt = bus.fetch_req_i & ~bus.load_req_i;
        if (bus.load_req_i)
          state_d = busy ? DRAIN : LOAD;
      end
      DRAIN: begin
        if (!bus.load_req_i) state_d = RUN;
        else if (!busy)      state_d = LOAD;
      end
      LOAD: begin
        load_gnt = bus.load_req_i;
        if (!bus.load_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (fetch_gnt && !fetch_bad) begin
      csb  = 1'b0;
      addr = bus.fetch_addr_i[SRAM_AW+1:2];
    end
    if (load_gnt) begin
      load_err = load_bad;
      if (!load_bad) begin
        csb   = 1'b0;
        web   = 1'b0;
        wmask = bus.load_be_i;
        addr  = bus.load_addr_i[SRAM_AW+1:2];
        din   = bus.load_wdata_i;
      end
    end
  end

  // Valid/err tag shift register, one slot per cycle of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
    end else begin
      vld_q <= {vld_q[RD_LATENCY-2:0], fetch_gnt};
      err_q <= {err_q[RD_LATENCY-2:0], fetch_gnt & fetch_bad};
    end
  end

  // Capture macro data the cycle after the grant, then delay to match tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < RD_LATENCY; k++) dat_q[k] <= '0;
    end else begin
      dat_q[1] <= (vld_q[0] && !err_q[0]) ? bus.sram_dout0_i : '0;
      for (int k = 2; k < RD_LATENCY; k++) dat_q[k] <= dat_q[k-1];
    end
  end

`ifdef IMEM_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles a fetch waits without a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (bus.fetch_req_i && !fetch_gnt && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

  assign bus.fetch_gnt_o    = fetch_gnt;
  assign bus.fetch_rvalid_o = vld_q[RD_LATENCY-1];
  assign bus.fetch_err_o    = vld_q[RD_LATENCY-1] & err_q[RD_LATENCY-1];
  assign bus.fetch_rdata_o  = dat_q[RD_LATENCY-1];
  assign bus.load_gnt_o     = load_gnt;
  assign bus.load_err_o     = load_err;
  assign bus.sram_csb0_o    = csb;
  assign bus.sram_web0_o    = web;
  assign bus.sram_wmask0_o  = wmask;
  assign bus.sram_addr0_o   = addr;
  assign bus.sram_din0_o    = din;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a falling-edge SRAM model.
// Expected values are hand-computed constants.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stall_cnt;
  int          n_run = 0;
  int          n_fail = 0;
  int          csb_lo;
  logic [31:0] mem [256];
  logic [7:0]  raddr = 8'd0;

  imem_port_arbiter_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SRAM_AW(8)
  ) bus ();

  imem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .SRAM_AW(8), .RD_LATENCY(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  // SRAM model: sample on rise, data out on fall
  always @(posedge clk) begin
    if (!bus.sram_csb0_o) begin
      if (!bus.sram_web0_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wmask0_o[b])
            mem[bus.sram_addr0_o][b*8 +: 8] <= bus.sram_din0_o[b*8 +: 8];
      end else begin
        raddr <= bus.sram_addr0_o;
      end
    end
  end

  always @(negedge clk) bus.sram_dout0_i <= mem[raddr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_req_i  = 1'b0;
    bus.fetch_addr_i = '0;
    bus.load_req_i   = 1'b0;
    bus.load_addr_i  = '0;
    bus.load_wdata_i = '0;
    bus.load_be_i    = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h1111_0000 + i;
    mem[8'h10] = 32'hDEAD_BEEF;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fgnt", {31'd0, bus.fetch_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.fetch_rvalid_o}, 32'd0);
    chk("rst_rdata", bus.fetch_rdata_o, 32'd0);
    chk("rst_ferr", {31'd0, bus.fetch_err_o}, 32'd0);
    chk("rst_lgnt", {31'd0, bus.load_gnt_o}, 32'd0);
    chk("rst_lerr", {31'd0, bus.load_err_o}, 32'd0);
    chk("rst_csb", {31'd0, bus.sram_csb0_o}, 32'd1);
    chk("rst_web", {31'd0, bus.sram_web0_o}, 32'd1);
    chk("rst_wmask", {28'd0, bus.sram_wmask0_o}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: single read
    bus.fetch_req_i  = 1'b1;
    bus.fetch_addr_i = 32'h40;
    #1;
    chk("t1_gnt", {31'd0, bus.fetch_gnt_o}, 32'd1);
    chk("t1_csb", {31'd0, bus.sram_csb0_o}, 32'd0);
    chk("t1_addr0", {24'd0, bus.sram_addr0_o}, 32'h10);
    step();
    idle();
    #1;
    chk("t1_rv_n1", {31'd0, bus.fetch_rvalid_o}, 32'd0);
    step();
    chk("t1_rv_n2", {31'd0, bus.fetch_rvalid_o}, 32'd1);
    chk("t1_rdata", bus.fetch_rdata_o, 32'hDEAD_BEEF);
    chk("t1_err", {31'd0, bus.fetch_err_o}, 32'd0);
    step();

    // 2: four back-to-back reads
    csb_lo = 0;
    for (int c = 0; c < 6; c++) begin
      bus.fetch_req_i  = (c < 4);
      bus.fetch_addr_i = 32'(c * 4);
      #1;
      if (!bus.sram_csb0_o) csb_lo++;
      if (c < 4) chk("t2_gnt", {31'd0, bus.fetch_gnt_o}, 32'd1);
      if (c >= 2) begin
        chk("t2_rvalid", {31'd0, bus.fetch_rvalid_o}, 32'd1);
        chk("t2_rdata", bus.fetch_rdata_o, 32'h1111_0000 + 32'(c - 2));
        chk("t2_err", {31'd0, bus.fetch_err_o}, 32'd0);
      end
      step();
    end
    idle();
    chk("t2_csb_lo", 32'(csb_lo), 32'd4);
    step();

    // 3: misaligned and out-of-range reads
    for (int c = 0; c < 4; c++) begin
      bus.fetch_req_i  = (c < 2);
      bus.fetch_addr_i = (c == 0) ? 32'h42 : 32'h400;
      #1;
      if (c < 2) begin
        chk("t3_gnt", {31'd0, bus.fetch_gnt_o}, 32'd1);
        chk("t3_csb", {31'd0, bus.sram_csb0_o}, 32'd1);
      end else begin
        chk("t3_rvalid", {31'd0, bus.fetch_rvalid_o}, 32'd1);
        chk("t3_err", {31'd0, bus.fetch_err_o}, 32'd1);
        chk("t3_rdata", bus.fetch_rdata_o, 32'd0);
      end
      step();
    end
    idle();
    step();

    // 4: load arrives with two reads in flight
    bus.fetch_req_i  = 1'b1;
    bus.fetch_addr_i = 32'h0;
    #1;
    chk("t4_gnt0", {31'd0, bus.fetch_gnt_o}, 32'd1);
    step();
    bus.fetch_addr_i = 32'h4;
    #1;
    chk("t4_gnt1", {31'd0, bus.fetch_gnt_o}, 32'd1);
    step();
    bus.fetch_addr_i = 32'h8;
    bus.load_req_i   = 1'b1;
    bus.load_addr_i  = 32'h8;
    bus.load_wdata_i = 32'h1234_5678;
    bus.load_be_i    = 4'hF;
    #1;
    chk("t4_c2_fgnt", {31'd0, bus.fetch_gnt_o}, 32'd0);
    chk("t4_c2_lgnt", {31'd0, bus.load_gnt_o}, 32'd0);
    chk("t4_c2_rv", {31'd0, bus.fetch_rvalid_o}, 32'd1);
    chk("t4_c2_rd", bus.fetch_rdata_o, 32'h1111_0000);
    step();
    chk("t4_c3_lgnt", {31'd0, bus.load_gnt_o}, 32'd0);
    chk("t4_c3_rv", {31'd0, bus.fetch_rvalid_o}, 32'd1);
    chk("t4_c3_rd", bus.fetch_rdata_o, 32'h1111_0001);
    step();
    chk("t4_c4_lgnt", {31'd0, bus.load_gnt_o}, 32'd0);
    chk("t4_c4_rv", {31'd0, bus.fetch_rvalid_o}, 32'd0);
    step();
    chk("t4_c5_lgnt", {31'd0, bus.load_gnt_o}, 32'd1);
    chk("t4_c5_fgnt", {31'd0, bus.fetch_gnt_o}, 32'd0);
    chk("t4_c5_csb", {31'd0, bus.sram_csb0_o}, 32'd0);
    chk("t4_c5_web", {31'd0, bus.sram_web0_o}, 32'd0);
    chk("t4_c5_addr", {24'd0, bus.sram_addr0_o}, 32'd2);
    chk("t4_c5_mask", {28'd0, bus.sram_wmask0_o}, 32'hF);
    chk("t4_c5_din", bus.sram_din0_o, 32'h1234_5678);
    step();
    bus.load_req_i = 1'b0;
    #1;
    chk("t4_c6_lgnt", {31'd0, bus.load_gnt_o}, 32'd0);
    chk("t4_c6_fgnt", {31'd0, bus.fetch_gnt_o}, 32'd0);
    step();
    chk("t4_c7_fgnt", {31'd0, bus.fetch_gnt_o}, 32'd1);
    chk("t4_c7_addr", {24'd0, bus.sram_addr0_o}, 32'd2);
`ifdef IMEM_STALL_CNT_EN
    chk("t4_stall", stall_cnt, 32'd5);
`else
    chk("t4_stall", stall_cnt, 32'd0);
`endif
    step();
    idle();
    #1;
    chk("t4_c8_rv", {31'd0, bus.fetch_rvalid_o}, 32'd0);
    step();
    chk("t4_c9_rv", {31'd0, bus.fetch_rvalid_o}, 32'd1);
    chk("t4_c9_rd", bus.fetch_rdata_o, 32'h1234_5678);
    step();

    // 5: simultaneous load/fetch, out-of-range load
    bus.fetch_req_i  = 1'b1;
    bus.fetch_addr_i = 32'h0;
    bus.load_req_i   = 1'b1;
    bus.load_addr_i  = 32'h1000;
    bus.load_wdata_i = 32'hCAFE_F00D;
    bus.load_be_i    = 4'hF;
    #1;
    chk("t5_c0_fgnt", {31'd0, bus.fetch_gnt_o}, 32'd0);
    chk("t5_c0_lgnt", {31'd0, bus.load_gnt_o}, 32'd0);
    step();
    bus.fetch_req_i = 1'b0;
    #1;
    chk("t5_c1_lgnt", {31'd0, bus.load_gnt_o}, 32'd1);
    chk("t5_c1_lerr", {31'd0, bus.load_err_o}, 32'd1);
    chk("t5_c1_csb", {31'd0, bus.sram_csb0_o}, 32'd1);
    step();
    bus.load_req_i = 1'b0;
    #1;
    chk("t5_c2_lerr", {31'd0, bus.load_err_o}, 32'd0);
    chk("t5_c2_lgnt", {31'd0, bus.load_gnt_o}, 32'd0);
    step();
    idle();
    step();

    // 6: reset with a read in flight
    bus.fetch_req_i  = 1'b1;
    bus.fetch_addr_i = 32'h0;
    #1;
    chk("t6_gnt", {31'd0, bus.fetch_gnt_o}, 32'd1);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rv", {31'd0, bus.fetch_rvalid_o}, 32'd0);
    chk("t6_rst_csb", {31'd0, bus.sram_csb0_o}, 32'd1);
    chk("t6_rst_stall", stall_cnt, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t6_no_rv", {31'd0, bus.fetch_rvalid_o}, 32'd0);
      chk("t6_csb", {31'd0, bus.sram_csb0_o}, 32'd1);
      step();
    end
    bus.fetch_req_i  = 1'b1;
    bus.fetch_addr_i = 32'h4;
    #1;
    chk("t6_run_gnt", {31'd0, bus.fetch_gnt_o}, 32'd1);
    step();
    idle();
    step();
    chk("t6_rv", {31'd0, bus.fetch_rvalid_o}, 32'd1);
    chk("t6_rd", bus.fetch_rdata_o, 32'h1111_0001);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
